// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_pkg;

  // Serializer FSM: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width: enough bits to count 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter over the bit positions of one word; flags the final position.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        enable,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        is_last
);

  localparam int CW = cnt_width(WIDTH);

  // Clear has priority so a new word (or end of word) always restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Final bit position of the word.
  always_comb begin
    is_last = (count == CW'(WIDTH - 1));
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a valid/ready word input and a
// one-bit-per-clock output carrying valid and last-bit markers.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
// in_ready depends only on registered state (IDLE, or the last-bit cycle of
// SHIFT), never on in_valid; in_data is only sampled on a transfer edge.
// out_valid marks every cycle that carries a live bit; out_last marks the
// final bit of each word. Holding in_valid through the last-bit cycle loads
// the next word on that edge with no idle cycle in between.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             is_last;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count),
    .is_last(is_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and serial outputs decoded from registered state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out       = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        cnt_en    = 1'b1;
        out       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        if (is_last) begin
          out_last  = 1'b1;
          in_ready  = 1'b1;
          state_nxt = in_valid ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
    // Restart the counter on a new word and when leaving the last bit, so
    // it never runs past WIDTH-1 and sits at 0 while idle.
    cnt_clear = accept | ((state == SHIFT) & is_last);
  end

  // Shift register: load on transfer, otherwise shift toward the output end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= in_data;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  // The counter must be parked at zero whenever no word is in flight.
  idle_count_zero: assert property (@(posedge clk) disable iff (!rst_n)
                                    (state == IDLE) |-> (count == '0));

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shifter; the transmit end of the lab's 4-bit serial-in/parallel-out structural shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a single serial line.
- Asserts a last-bit marker on the final bit of each word.
- With default parameters, its serial output feeds the SIPO `in` directly. WIDTH cycles after the first bit, the SIPO `out` equals the loaded word.

Parameters:
- WIDTH, 4, bits per word; legal range ≥ 2.
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first (matches the SIPO, which shifts in at the LSB); 0 = send bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- out  output  1  serial data bit.
- out_valid  output  1  out carries a live bit this cycle.
- out_last  output  1  out carries the final bit of the current word.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - out=0, out_valid=0, out_last=0, in_ready=1 (combinational from state).
- State IDLE:
  - in_ready=1, out_valid=0, out=0.
  - A word is accepted on the rising edge where in_valid & in_ready; it loads the shift register, count=0, and state goes to SHIFT.
- State SHIFT:
  - out_valid=1.
  - out = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - Each clock, shift toward the output end (zero-fill) and increment count.
- out_last:
  - Asserted when count==WIDTH-1.
- Latency:
  - First bit appears in the cycle immediately after the accepting edge.
  - Word occupies exactly WIDTH consecutive cycles.
- in_ready:
  - 1 in IDLE.
  - 1 in SHIFT only when count==WIDTH-1 (last bit); 0 otherwise.
  - It is a combinational function of state and count only, never of in_valid.
- Back-to-back:
  - If in_valid=1 during the last-bit cycle, the new word loads on that edge, count resets to 0, and state stays SHIFT.
  - out_valid therefore stays high with no bubble.
- End of word:
  - If in_valid=0 during the last-bit cycle, the next state is IDLE: out_valid=0, out=0.
- Input during shift:
  - in_valid is ignored while in_ready=0.
  - in_data may change freely and is not sampled.
- Counter:
  - Width $clog2(WIDTH).
  - Never exceeds WIDTH-1; no wrap in normal operation.
- Reset mid-word:
  - Immediately forces the IDLE outputs.
  - The partial word is discarded and never resumed.
- All outputs are registered or decoded from registered state.
  - No combinational path from in_data to out.

Decomposition:
- Package piso_pkg:
  - State enum with IDLE=1'b0 and SHIFT=1'b1.
  - Function for the counter width (clog2 of WIDTH).
- One natural sub-module: piso_bit_counter, a WIDTH-aware up-counter.
  - Inputs: clear, enable.
  - Outputs: count, is_last.
- Top-level keeps the FSM, shift register and handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with in_valid=0 → out=0, out_valid=0, out_last=0, in_ready=1 for 4 further cycles.
- Single word: in_data=4'b1011 accepted at edge t → out = 1,0,1,1 in cycles t+1..t+4.
  - out_valid=1 in those cycles.
  - out_last=1 only at t+4; in_ready=0 at t+1..t+3 and 1 at t+4.
  - out_valid=0 at t+5.
- Back-to-back: words 4'b1011 then 4'b0110, with in_valid held high → 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - out_last is high on bits 4 and 8; no idle cycle between words.
- Loopback: drive out into shift_register_structural.in; send 16 random words → SIPO out equals each sent word in the cycle after its out_last bit.
- Reset mid-word: load 4'b1111, drop rst_n after 2 bits → out=0, out_valid=0 immediately.
  - After release: in_ready=1, and no remaining bits of 4'b1111 are ever emitted.
- LSB-first (MSB_FIRST=0, WIDTH=8): load 8'hA5 → out = 1,0,1,0,0,1,0,1, with out_last on the 8th bit.
